demux: RTL and testbench

DEMUX -- requirements
Module: demux

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_out_reg.sv | 24 ++
 rtl/demux.sv | 76 +++++++
 tb/tb_demux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared sizing helpers and architecture names for the serial-to-parallel demux.
package demux_pkg;
  localparam ARCH_BEHAVIORAL = "BEHAVIORAL";

  function automatic int lanes(input int select_lines);
    return 1 << select_lines;
  endfunction

  function automatic int frame_width(input int select_lines, input int data_width);
    return lanes(select_lines) * data_width;
  endfunction
endpackage

// File: rtl/demux_out_reg.sv
// Output frame register with valid/ready handshake; a load always wins over consumption.
module demux_out_reg #(
  parameter int FRAME_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] data_out,
  output logic               valid_out
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= frame;
      valid_out <= 1'b1;
    end else if (out_ready) begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: rtl/demux.sv
// Collects DATA_WIDTH words into 2**SELECT_LINES lanes and emits each full frame.
module demux
  import demux_pkg::*;
#(
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 2,
  parameter     ARCHITECTURE = ARCH_BEHAVIORAL
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [DATA_WIDTH-1:0]                            data_in,
  input  logic                                             en,
  input  logic                                             sync,
  output logic                                             in_ready,
  output logic [frame_width(SELECT_LINES, DATA_WIDTH)-1:0] data_out,
  output logic                                             valid_out,
  input  logic                                             out_ready,
  output logic [SELECT_LINES-1:0]                          select
);
  localparam int L       = lanes(SELECT_LINES);
  localparam int FRAME_W = frame_width(SELECT_LINES, DATA_WIDTH);
  localparam logic [SELECT_LINES-1:0] LAST = SELECT_LINES'(L - 1);

  // Only lanes 0..L-2 are buffered; the final word goes straight into the frame.
  logic [L-2:0][DATA_WIDTH-1:0] collect;
  logic [L-2:0]                 lane_wr;
  logic [FRAME_W-1:0]           frame;
  logic                         at_last, accept, load;

  assign at_last  = (select == LAST);
  assign in_ready = !(at_last && valid_out && !out_ready);
  assign accept   = en && in_ready;
  assign load     = accept && at_last && !sync;
  assign frame    = {data_in, collect};

  // Sync owns lane 0 regardless of backpressure, so it bypasses in_ready.
  always_comb begin
    lane_wr = '0;
    for (int k = 0; k < L - 1; k++) begin
      if (sync) lane_wr[k] = (k == 0) && en;
      else      lane_wr[k] = accept && (select == SELECT_LINES'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collect <= '0;
    end else begin
      for (int k = 0; k < L - 1; k++)
        if (lane_wr[k]) collect[k] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      select <= '0;
    else if (sync)   select <= SELECT_LINES'(en);
    else if (accept) select <= at_last ? '0 : select + 1'b1;
  end

  generate
    if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_beh
      demux_out_reg #(.FRAME_W(FRAME_W)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .frame     (frame),
        .out_ready (out_ready),
        .data_out  (data_out),
        .valid_out (valid_out)
      );
    end else begin : g_unsupported
      assign data_out  = '0;
      assign valid_out = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_demux.sv
// Scoreboard bench for demux: directed frames with hand-computed values, then a random run vs a model.
module tb_demux;
  localparam int SL = 4;
  localparam int DW = 2;
  localparam int L  = 16;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          en = 1'b0, sync = 1'b0, out_ready = 1'b0;
  logic          in_ready, valid_out;
  logic [FW-1:0] data_out;
  logic [SL-1:0] select;

  demux #(.SELECT_LINES(SL), .DATA_WIDTH(DW), .ARCHITECTURE("BEHAVIORAL")) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .en(en), .sync(sync),
    .in_ready(in_ready), .data_out(data_out), .valid_out(valid_out),
    .out_ready(out_ready), .select(select)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [FW-1:0] q[$];
  bit use_model = 1'b0;

  // Reference state: predicted in_ready/select for the current cycle, plus lane contents.
  logic [DW-1:0] m_coll [L];
  logic [SL-1:0] m_sel;
  logic          m_valid;
  logic          exp_rdy;
  logic [SL-1:0] exp_sel;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < L; i++) m_coll[i] = '0;
    m_sel = '0; m_valid = 1'b0; exp_rdy = 1'b1; exp_sel = '0;
  endfunction

  function automatic void model_edge(input logic e, input logic s, input logic [DW-1:0] d, input logic r);
    logic rdy;
    logic [FW-1:0] f;
    rdy = !(m_sel == 4'd15 && m_valid && !r);
    exp_rdy = rdy;
    exp_sel = m_sel;
    if (m_valid && r) m_valid = 1'b0;
    if (s) begin
      if (e) begin m_coll[0] = d; m_sel = 4'd1; end
      else m_sel = 4'd0;
    end else if (e && rdy) begin
      if (m_sel == 4'd15) begin
        f = '0;
        for (int i = 0; i < L - 1; i++) f[i*DW +: DW] = m_coll[i];
        f[(L-1)*DW +: DW] = d;
        m_valid = 1'b1;
        m_sel = 4'd0;
        if (use_model) q.push_back(f);
      end else begin
        m_coll[m_sel] = d;
        m_sel = m_sel + 4'd1;
      end
    end
  endfunction

  task automatic step(input logic e, input logic s, input logic [DW-1:0] d, input logic r);
    en = e; sync = s; data_in = d; out_ready = r;
    model_edge(e, s, d, r);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; sync = 1'b0; out_ready = 1'b0;
    model_reset();
    q.delete();
    #2;
    chk("reset_select", 64'(select), 64'd0);
    chk("reset_valid", 64'(valid_out), 64'd0);
    chk("reset_data", 64'(data_out), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: per-cycle handshake checks and frame pops on each consumption.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("select", 64'(select), 64'(exp_sel));
      if (valid_out && out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_frame: got %h expected none", data_out);
        end else begin
          chk("frame", 64'(data_out), 64'(q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [FW-1:0] held;
    model_reset();
    do_reset();

    // Counting pattern 0,1,2,3 -> E4 per byte.
    for (int i = 0; i < 16; i++) step(1, 0, DW'(i % 4), 1);
    q.push_back(32'hE4E4E4E4);
    step(0, 0, 0, 1);
    chk("select_wrap", 64'(select), 64'd0);

    // Back-to-back all-ones, two frames.
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 2'b11, 1);
      if (i == 15) q.push_back(32'hFFFFFFFF);
    end
    q.push_back(32'hFFFFFFFF);
    step(0, 0, 0, 1);

    // Backpressure: pending frame stalls the final lane of the next one.
    for (int i = 0; i < 16; i++) step(1, 0, DW'(i % 4), 0);
    q.push_back(32'hE4E4E4E4);
    for (int i = 0; i < 15; i++) step(1, 0, 2'b01, 0);
    held = data_out;
    step(1, 0, 2'b01, 0);
    step(1, 0, 2'b01, 0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_data_stable", 64'(data_out), 64'(held));
    chk("stall_data_value", 64'(data_out), 64'hE4E4E4E4);
    chk("stall_valid", 64'(valid_out), 64'd1);
    step(1, 0, 2'b01, 1);
    q.push_back(32'h55555555);
    step(0, 0, 0, 1);

    // Sync with data realigns; partial ones are dropped.
    for (int i = 0; i < 5; i++) step(1, 0, 2'b11, 1);
    step(1, 1, 2'b01, 1);
    for (int i = 0; i < 15; i++) step(1, 0, 2'b00, 1);
    q.push_back(32'h00000001);
    step(0, 0, 0, 1);

    // Sync without data clears the partial frame.
    for (int i = 0; i < 3; i++) step(1, 0, 2'b11, 1);
    step(0, 1, 2'b00, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 2'b01, 1);
    q.push_back(32'h55555555);
    step(0, 0, 0, 1);

    // Sync honoured while stalled at the final lane.
    for (int i = 0; i < 16; i++) step(1, 0, 2'b10, 0);
    q.push_back(32'hAAAAAAAA);
    for (int i = 0; i < 15; i++) step(1, 0, 2'b01, 0);
    step(1, 1, 2'b11, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(1, 0, 2'b00, 1);
    q.push_back(32'h00000003);
    step(0, 0, 0, 1);

    // Reset mid-frame, then reset with a frame pending.
    for (int i = 0; i < 9; i++) step(1, 0, 2'b11, 1);
    chk("pre_reset_select", 64'(select), 64'd9);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 2'b11, 0);
    chk("pre_reset_valid", 64'(valid_out), 64'd1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 2'b10, 1);
    q.push_back(32'hAAAAAAAA);
    step(0, 0, 0, 1);
    chk("directed_drained", 64'(q.size()), 64'd0);

    // Random traffic against the model.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           DW'($urandom), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("random_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
